// File: rtl/shift_pkg.sv
// Shared types and helpers for the iterative shift functional unit.
package shift_pkg;

   typedef enum logic [2:0] {
      MODE_SLL = 3'd0,
      MODE_SRL = 3'd1,
      MODE_SRA = 3'd2,
      MODE_ROL = 3'd3,
      MODE_ROR = 3'd4
   } shift_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_OUTPUT = 2'd2
   } shift_state_e;

   // Positions to shift this cycle: never more than what is left to do.
   function automatic int clamp_step(input int remaining, input int step);
      return (remaining < step) ? remaining : step;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts value by s positions in the given mode.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int S_W   = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] value,
   input  logic [2:0]       mode,
   input  logic [S_W-1:0]   s,
   output logic [WIDTH-1:0] result
);

   logic [2*WIDTH-1:0] w_dbl_l;
   logic [2*WIDTH-1:0] w_dbl_r;

   // Rotates come from shifting a doubled copy and taking the wrapped half.
   assign w_dbl_l = {value, value} << s;
   assign w_dbl_r = {value, value} >> s;

   always_comb begin
      result = value << s;
      case (mode)
         MODE_SRL: result = value >> s;
         MODE_SRA: result = $signed(value) >>> s;
         MODE_ROL: result = w_dbl_l[2*WIDTH-1:WIDTH];
         MODE_ROR: result = w_dbl_r[WIDTH-1:0];
         default:  ;
      endcase
   end

endmodule

// File: rtl/shiftfu_multi.sv
// Iterative multi-mode shift FU: latches one micro-op, shifts STEP positions per
// cycle, then holds the result until both the CDB and the ROB have taken it.
module shiftfu_multi
   import shift_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int ROBID_W = 4,
   parameter int STEP    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    input_transmit,
   input  logic [7:0]              operand,
   input  logic [1:0][WIDTH-1:0]   depvals,
   input  logic [7:0]              wbs,
   input  logic [7:0]              flags,
   input  logic [ROBID_W-1:0]      robid,
   input  logic                    cdb_transmit,
   output logic                    cdb_transmit_out,
   output logic [ROBID_W-1:0]      cdb_id,
   output logic [WIDTH-1:0]        cdb_val,
   input  logic                    rob_transmit,
   output logic                    rob_transmit_out,
   output logic [ROBID_W-1:0]      robid_out,
   output logic [7:0]              flags_out,
   output logic [7:0]              wbs_out,
   output logic [WIDTH-1:0]        value_out,
   output logic                    busy
);

   localparam int AMT_W = $clog2(WIDTH);
   localparam int CNT_W = AMT_W + 1;

   shift_state_e       r_state;
   shift_state_e       w_next;
   logic [WIDTH-1:0]   r_work;
   logic [2:0]         r_mode;
   logic [CNT_W-1:0]   r_rem;
   logic [ROBID_W-1:0] r_robid;
   logic [7:0]         r_flags;
   logic [7:0]         r_wbs;
   logic               r_cdb_req;
   logic               r_rob_req;
   logic               r_cdb_pend;
   logic               r_rob_pend;
   logic               r_busy;

   logic [CNT_W-1:0]   w_amt;
   logic [CNT_W-1:0]   w_s;
   logic [WIDTH-1:0]   w_shifted;
   logic               w_cdb_done;
   logic               w_rob_done;
   logic               w_unused;

   assign w_amt      = {1'b0, depvals[1][AMT_W-1:0]};
   assign w_s        = CNT_W'(clamp_step(int'(r_rem), STEP));
   assign w_cdb_done = !r_cdb_pend || (r_cdb_req && cdb_transmit);
   assign w_rob_done = !r_rob_pend || (r_rob_req && rob_transmit);
   assign w_unused   = ^{operand[7:3], depvals[1][WIDTH-1:AMT_W]};

   shift_step #(.WIDTH(WIDTH), .S_W(CNT_W)) u_step (
      .value  (r_work),
      .mode   (r_mode),
      .s      (w_s),
      .result (w_shifted)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (input_transmit) w_next = (w_amt != '0) ? ST_SHIFT : ST_OUTPUT;
         ST_SHIFT:  if (w_s == r_rem) w_next = ST_OUTPUT;
         ST_OUTPUT: if (w_cdb_done && w_rob_done) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != ST_IDLE);
      end
   end

   // Requests rise one cycle after OUTPUT is entered so every output stays registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work     <= '0;
         r_mode     <= '0;
         r_rem      <= '0;
         r_robid    <= '0;
         r_flags    <= '0;
         r_wbs      <= '0;
         r_cdb_req  <= 1'b0;
         r_rob_req  <= 1'b0;
         r_cdb_pend <= 1'b0;
         r_rob_pend <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (input_transmit) begin
                  r_work  <= depvals[0];
                  r_mode  <= operand[2:0];
                  r_rem   <= w_amt;
                  r_robid <= robid;
                  r_flags <= flags;
                  r_wbs   <= wbs;
               end
            end
            ST_SHIFT: begin
               r_work <= w_shifted;
               r_rem  <= r_rem - w_s;
            end
            ST_OUTPUT: begin
               if (r_cdb_req && cdb_transmit) begin
                  r_cdb_req  <= 1'b0;
                  r_cdb_pend <= 1'b0;
               end else begin
                  r_cdb_req <= r_cdb_pend;
               end
               if (r_rob_req && rob_transmit) begin
                  r_rob_req  <= 1'b0;
                  r_rob_pend <= 1'b0;
               end else begin
                  r_rob_req <= r_rob_pend;
               end
            end
            default: ;
         endcase
         if (r_state != ST_OUTPUT && w_next == ST_OUTPUT) begin
            r_cdb_pend <= 1'b1;
            r_rob_pend <= 1'b1;
         end
      end
   end

   assign cdb_transmit_out = r_cdb_req;
   assign rob_transmit_out = r_rob_req;
   assign cdb_id           = r_robid;
   assign robid_out        = r_robid;
   assign cdb_val          = r_work;
   assign value_out        = r_work;
   assign flags_out        = r_flags;
   assign wbs_out          = r_wbs;
   assign busy             = r_busy;

endmodule

// File: tb/tb_shiftfu_multi.sv
// Bench for shiftfu_multi: directed and random micro-ops on an 8-bit/STEP=2 unit
// and a 16-bit/STEP=4 unit, compared against an arithmetic reference model.
module tb_shiftfu_multi;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            it8, cdbg8, robg8, cdbo8, robo8, busy8;
   logic [7:0]      op8, wbs8, fl8, cval8, vo8, flo8, wbso8;
   logic [1:0][7:0] dv8;
   logic [3:0]      rid8, cid8, rido8;

   logic             it16, cdbg16, robg16, cdbo16, robo16, busy16;
   logic [7:0]       op16, wbs16, fl16, flo16, wbso16;
   logic [15:0]      cval16, vo16;
   logic [1:0][15:0] dv16;
   logic [3:0]       rid16, cid16, rido16;

   int n_cmp  = 0;
   int n_fail = 0;

   shiftfu_multi #(.WIDTH(8), .ROBID_W(4), .STEP(2)) dut8 (
      .clk(clk), .rst(rst), .input_transmit(it8), .operand(op8), .depvals(dv8),
      .wbs(wbs8), .flags(fl8), .robid(rid8), .cdb_transmit(cdbg8),
      .cdb_transmit_out(cdbo8), .cdb_id(cid8), .cdb_val(cval8),
      .rob_transmit(robg8), .rob_transmit_out(robo8), .robid_out(rido8),
      .flags_out(flo8), .wbs_out(wbso8), .value_out(vo8), .busy(busy8)
   );

   shiftfu_multi #(.WIDTH(16), .ROBID_W(4), .STEP(4)) dut16 (
      .clk(clk), .rst(rst), .input_transmit(it16), .operand(op16), .depvals(dv16),
      .wbs(wbs16), .flags(fl16), .robid(rid16), .cdb_transmit(cdbg16),
      .cdb_transmit_out(cdbo16), .cdb_id(cid16), .cdb_val(cval16),
      .rob_transmit(robg16), .rob_transmit_out(robo16), .robid_out(rido16),
      .flags_out(flo16), .wbs_out(wbso16), .value_out(vo16), .busy(busy16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Result of shifting a by b (mod w) in the given mode, from the textbook definitions.
   function automatic logic [63:0] ref_shift(input int w, input int mode,
                                             input logic [63:0] a_in, input logic [63:0] b);
      logic [63:0] m, a, r;
      longint      s;
      int          amt;
      m   = (64'd1 << w) - 64'd1;
      a   = a_in & m;
      amt = int'(b % 64'(w));
      case (mode)
         1: r = a >> amt;
         2: begin
            s = a[w-1] ? longint'(a | ~m) : longint'(a);
            r = 64'(s >>> amt) & m;
         end
         3: r = ((a << amt) | (a >> (w - amt))) & m;
         4: r = ((a >> amt) | (a << (w - amt))) & m;
         default: r = (a << amt) & m;
      endcase
      return r;
   endfunction

   task automatic run8(input int mode, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input int dr, input int dc);
      int amt, lat, mx;
      logic [3:0] tag;
      logic [7:0] fl, wb;
      amt = int'(b) % 8;
      lat = 1 + (amt + 1) / 2;
      tag = 4'($urandom);
      fl  = 8'($urandom);
      wb  = 8'($urandom);
      it8 = 1'b1; op8 = {5'($urandom), 3'(mode)}; dv8[0] = a; dv8[1] = b;
      rid8 = tag; fl8 = fl; wbs8 = wb;
      tick();
      it8 = 1'b0; dv8[0] = 8'($urandom); dv8[1] = 8'($urandom);
      rid8 = 4'($urandom); fl8 = 8'($urandom); wbs8 = 8'($urandom);
      chk("busy_after_dispatch", 64'(busy8), 64'd1);
      for (int k = 1; k < lat; k++) begin
         tick();
         chk("req_before_latency", 64'({cdbo8, robo8}), 64'd0);
      end
      tick();
      chk("cdb_req_rise", 64'(cdbo8), 64'd1);
      chk("rob_req_rise", 64'(robo8), 64'd1);
      chk("value_out", 64'(vo8), 64'(exp));
      chk("cdb_val", 64'(cval8), 64'(exp));
      chk("cdb_id", 64'(cid8), 64'(tag));
      chk("robid_out", 64'(rido8), 64'(tag));
      chk("flags_out", 64'(flo8), 64'(fl));
      chk("wbs_out", 64'(wbso8), 64'(wb));
      mx = (dr > dc) ? dr : dc;
      for (int c = 0; c <= mx; c++) begin
         robg8 = (c == dr); cdbg8 = (c == dc);
         tick();
         robg8 = 1'b0; cdbg8 = 1'b0;
         chk("cdb_req_hs", 64'(cdbo8), 64'(c < dc));
         chk("rob_req_hs", 64'(robo8), 64'(c < dr));
         chk("busy_hs", 64'(busy8), 64'(c < mx));
         if (c < dc) chk("cdb_val_hold", 64'(cval8), 64'(exp));
      end
   endtask

   task automatic run16(input int mode, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
      int amt, lat;
      logic [3:0] tag;
      amt = int'(b) % 16;
      lat = 1 + (amt + 3) / 4;
      tag = 4'($urandom);
      it16 = 1'b1; op16 = {5'd0, 3'(mode)}; dv16[0] = a; dv16[1] = b; rid16 = tag;
      tick();
      it16 = 1'b0; dv16[0] = 16'($urandom);
      for (int k = 1; k < lat; k++) begin
         tick();
         chk("w16_req_before_latency", 64'(cdbo16), 64'd0);
      end
      tick();
      chk("w16_cdb_req", 64'(cdbo16), 64'd1);
      chk("w16_value_out", 64'(vo16), 64'(exp));
      chk("w16_cdb_id", 64'(cid16), 64'(tag));
      cdbg16 = 1'b1; robg16 = 1'b1;
      tick();
      cdbg16 = 1'b0; robg16 = 1'b0;
      chk("w16_busy_after_grant", 64'({busy16, cdbo16, robo16}), 64'd0);
   endtask

   initial begin
      int m;
      logic [7:0] ra, rb;
      logic [15:0] wa, wb16;
      rst = 1'b1;
      it8 = 0; op8 = 0; dv8 = '0; wbs8 = 0; fl8 = 0; rid8 = 0; cdbg8 = 0; robg8 = 0;
      it16 = 0; op16 = 0; dv16 = '0; wbs16 = 0; fl16 = 0; rid16 = 0; cdbg16 = 0; robg16 = 0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_ctrl8", 64'({busy8, cdbo8, robo8}), 64'd0);
      chk("reset_data8", 64'({cval8, vo8, cid8, rido8, flo8, wbso8}), 64'd0);
      chk("reset_ctrl16", 64'({busy16, cdbo16, robo16, vo16}), 64'd0);
      tick();

      run8(0, 8'h81, 8'd3, 8'h08, 0, 0);
      run8(2, 8'h90, 8'd4, 8'hF9, 1, 0);
      run8(1, 8'h90, 8'd4, 8'h09, 0, 1);
      run8(4, 8'h81, 8'd1, 8'hC0, 0, 0);
      run8(3, 8'h81, 8'd9, 8'h03, 0, 0);
      run8(0, 8'h5A, 8'd0, 8'h5A, 0, 0);
      run8(6, 8'h01, 8'd2, 8'h04, 1, 1);
      run8(0, 8'h81, 8'd3, 8'h08, 0, 2);
      run8(1, 8'hF0, 8'd2, 8'h3C, 1, 1);

      for (int i = 0; i < 40; i++) begin
         m  = int'($urandom_range(0, 7));
         ra = 8'($urandom);
         rb = 8'($urandom);
         run8(m, ra, rb, 8'(ref_shift(8, m, 64'(ra), 64'(rb))),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      it8 = 1'b1; op8 = 8'd0; dv8[0] = 8'hFF; dv8[1] = 8'd7; rid8 = 4'hA;
      fl8 = 8'h5C; wbs8 = 8'h3E;
      tick();
      it8 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midshift_reset_ctrl", 64'({busy8, cdbo8, robo8}), 64'd0);
      chk("midshift_reset_data", 64'({cval8, vo8, cid8, rido8, flo8, wbso8}), 64'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("discarded_op_silent", 64'({busy8, cdbo8, robo8}), 64'd0);
      end
      run8(2, 8'h80, 8'd7, 8'hFF, 0, 0);

      run16(0, 16'h8001, 16'd15, 16'h8000);
      for (int i = 0; i < 12; i++) begin
         m    = int'($urandom_range(0, 4));
         wa   = 16'($urandom);
         wb16 = 16'($urandom);
         run16(m, wa, wb16, 16'(ref_shift(16, m, 64'(wa), 64'(wb16))));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
